// File: rtl/dac_sample_feeder.sv
// Sample-rate FIFO feeding the DAC: producer pushes, divider pops one sample per period; Sample/flags registered, 1-cycle latency.
// Writes while Full are dropped; pops on empty give midscale and set Underrun. Optional Irq refill request under DAC_FEED_IRQ_EN.
module dac_sample_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          push_vld,
  input  logic [DW-1:0] push_dat,
  input  logic          pop_vld,
  output logic [DW-1:0] head_dat,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);
  localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (level == DEPTH);
  assign empty    = (level == '0);
  assign do_push  = push_vld && !full;
  assign do_pop   = pop_vld && !empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

module dac_sample_feeder #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [7:0]           WrData,
  input  logic                 WrEn,
  output logic                 Full,
  output logic [DEPTH_LOG2:0]  Level,
  input  logic                 Enable,
  input  logic [DIV_WIDTH-1:0] Divisor,
  output logic [7:0]           Sample,
  output logic                 Underrun,
  input  logic                 UnderrunClr
`ifdef DAC_FEED_IRQ_EN
  ,
  output logic                 Irq
`endif
);
  localparam logic [7:0] MIDSCALE = 8'h80;

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] period_m1;
  logic                 tick;
  logic                 empty;
  logic [7:0]           head_dat;

  // Divisor 0 behaves as 1; >= lets a shrunk divisor tick immediately instead of wrapping.
  assign period_m1 = (Divisor == '0) ? '0 : Divisor - DIV_WIDTH'(1);
  assign tick      = Enable && (cnt >= period_m1);

  dac_sample_fifo #(.DW(8), .AW(DEPTH_LOG2)) u_fifo (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .push_vld (WrEn),
    .push_dat (WrData),
    .pop_vld  (tick),
    .head_dat (head_dat),
    .level    (Level),
    .full     (Full),
    .empty    (empty)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cnt      <= '0;
      Sample   <= MIDSCALE;
      Underrun <= 1'b0;
    end else begin
      if (!Enable)   cnt <= '0;
      else if (tick) cnt <= '0;
      else           cnt <= cnt + DIV_WIDTH'(1);

      if (tick) Sample <= empty ? MIDSCALE : head_dat;

      if (tick && empty)    Underrun <= 1'b1;
      else if (UnderrunClr) Underrun <= 1'b0;
    end
  end

`ifdef DAC_FEED_IRQ_EN
  localparam logic [DEPTH_LOG2:0] HALF = (DEPTH_LOG2+1)'(2**(DEPTH_LOG2-1));

  always_ff @(posedge Clk) begin
    if (!Reset_n) Irq <= 1'b0;
    else          Irq <= Enable && (Level <= HALF);
  end
`endif
endmodule

// File: doc/dac_sample_feeder.md
# dac_sample_feeder

Sample-rate buffer directly upstream of the sigma-delta DAC. A producer (CPU or a sequencer) pushes 8-bit unsigned audio samples into a small FIFO. A programmable divider pops one sample per sample period. The popped sample is held on `Sample`, which drives the DAC's 8-bit input, and stays stable for the whole period. On underrun the output goes to midscale.

## Interface

Parameters:
- `DEPTH_LOG2`, 4: FIFO depth is 2**DEPTH_LOG2 entries.
- `DIV_WIDTH`, 16: width of the sample-period divisor.

Ports:
- `Clk` in 1: single clock; all logic is on the rising edge.
- `Reset_n` in 1: reset, synchronous, active-low.
- `WrData` in 8: sample to push; unsigned, 0x80 = midscale.
- `WrEn` in 1: push strobe, one sample per cycle.
- `Full` out 1: FIFO holds 2**DEPTH_LOG2 entries.
- `Level` out DEPTH_LOG2+1: current number of entries.
- `Enable` in 1: run the sample clock.
- `Divisor` in DIV_WIDTH: sample period in Clk cycles; 0 is treated as 1.
- `Sample` out 8: registered sample, connects to the DAC input.
- `Underrun` out 1: sticky flag, set when a pop finds the FIFO empty.
- `UnderrunClr` in 1: clears `Underrun`.
- `Irq` out 1: present only with `DAC_FEED_IRQ_EN`.

## Operation

**Reset** (`Reset_n`=0 at an edge):
- `Sample`=0x80.
- `Level`=0, `Full`=0, `Underrun`=0.
- Period counter is 0 and FIFO pointers are 0.
- FIFO contents are don't-care.

**Period counter `cnt`** (DIV_WIDTH bits):
- Effective period: P = max(`Divisor`, 1).
- `Enable`=0: `cnt`<=0, no ticks, `Sample` holds its value.
- `Enable`=1: `tick` = (`cnt` >= P-1). On tick `cnt`<=0; otherwise `cnt`<=`cnt`+1.
- The `>=` compare means that shrinking `Divisor` mid-period ticks on the next cycle. It never wraps through 2**DIV_WIDTH.

**Pop on tick:**
- FIFO non-empty: `Sample`<=head entry, read pointer advances, `Level` decrements.
- FIFO empty: `Sample`<=0x80 and `Underrun`<=1. Pointers are unchanged.

**Push:**
- `WrEn`=1 and `Full`=0: entry is written at the write pointer, which advances; `Level` increments.
- `WrEn`=1 and `Full`=1: write is dropped silently and no state changes. `Full` is the pre-edge value, so a simultaneous pop does not make room in the same cycle.

**Simultaneous push and pop, FIFO non-empty:** both happen and `Level` is unchanged.

**Simultaneous push and pop, FIFO empty:** this is an underrun. The pushed sample is stored and is not bypassed to `Sample`. `Level` becomes 1.

**`Underrun` flag:** a set and `UnderrunClr` in the same cycle leaves the flag set (set wins).

**Pointers:** DEPTH_LOG2 bits, wrapping naturally. `Full` = (`Level` == 2**DEPTH_LOG2).

## Timing

- `Sample` changes only at the edge closing a tick cycle, and is stable for exactly P cycles between changes.
- First tick after `Enable` rises: in the P-th cycle with `Enable`=1. `Sample` updates at the end of that cycle.
- Push to visible: data written at edge N can be popped by a tick in cycle N+1 or later.
- `Level`, `Full` and `Underrun` are registered and update at the same edge as the operation that causes them.
- Deasserting `Enable` mid-period discards the partial count. Re-enabling starts a full period.
- Reset mid-operation discards FIFO contents and returns to midscale at the next edge.

## Configuration

`DAC_FEED_IRQ_EN`:
- **Defined:** adds port `Irq` (out, 1). `Irq` is registered and equals `Enable` & (`Level` <= 2**(DEPTH_LOG2-1)), computed from post-edge values. It lags `Level` by at most one cycle and resets to 0. Used as the refill request.
- **Undefined:** no `Irq` port and no related logic. Producers poll `Level`.

## Test plan

- **Reset:** hold `Reset_n`=0 for 2 cycles → `Sample`=0x80, `Level`=0, `Full`=0, `Underrun`=0.
- **Basic pacing:** `Divisor`=4; push 0x10, 0x20, 0x30; raise `Enable` → `Sample` goes 0x10, 0x20, 0x30 at 4-cycle spacing. The next tick gives 0x80 and `Underrun`=1.
- **Overflow:** 17 pushes with `Enable`=0 → `Full`=1 after the 16th and `Level`=16. The 17th is dropped. Then pop all 16 with `Divisor`=1 → the first 16 values come out in order.
- **Divisor edge cases:**
  - `Divisor`=0 → a tick every enabled cycle.
  - `Divisor` changed from 100 to 3 at `cnt`=50 → tick on the next cycle, then every 3 cycles.
- **Simultaneous events:**
  - Push and tick on an empty FIFO → `Sample`=0x80, `Underrun`=1, `Level`=1.
  - `UnderrunClr` in the same cycle as an underrun → `Underrun` stays 1.
- **With `DAC_FEED_IRQ_EN`:** DEPTH_LOG2=4, 10 entries, `Enable`=1, `Divisor`=2 → `Irq` rises one cycle after `Level` reaches 8. `Irq` is 0 while `Enable`=0.
